// File: rtl/tone_player_pkg.sv
// Shared constants for the buzzer output path: note table, note codes,
// player states and the millisecond/debounce tick counts at 100 MHz.
package tone_player_pkg;

    localparam int unsigned HALF_W = 18;
    localparam int unsigned TABLE_CLK_HZ = 100_000_000;
    localparam int unsigned TIME_1MS_CLK = 100_000;
    localparam int unsigned TIME_20MS_CLK = 2_000_000;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_C4 = 5'd1;
    localparam logic [4:0] NOTE_D4 = 5'd2;
    localparam logic [4:0] NOTE_E4 = 5'd3;
    localparam logic [4:0] NOTE_F4 = 5'd4;
    localparam logic [4:0] NOTE_G4 = 5'd5;
    localparam logic [4:0] NOTE_A4 = 5'd6;
    localparam logic [4:0] NOTE_B4 = 5'd7;
    localparam logic [4:0] NOTE_C5 = 5'd8;
    localparam logic [4:0] NOTE_D5 = 5'd9;
    localparam logic [4:0] NOTE_E5 = 5'd10;
    localparam logic [4:0] NOTE_F5 = 5'd11;
    localparam logic [4:0] NOTE_G5 = 5'd12;
    localparam logic [4:0] NOTE_A5 = 5'd13;
    localparam logic [4:0] NOTE_B5 = 5'd14;
    localparam logic [4:0] NOTE_C6 = 5'd15;
    localparam logic [4:0] NOTE_D6 = 5'd16;
    localparam logic [4:0] NOTE_E6 = 5'd17;
    localparam logic [4:0] NOTE_F6 = 5'd18;
    localparam logic [4:0] NOTE_G6 = 5'd19;
    localparam logic [4:0] NOTE_A6 = 5'd20;
    localparam logic [4:0] NOTE_B6 = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period in 100 MHz clocks, A4 = 440 Hz; zero marks a rest code.
    localparam logic [HALF_W-1:0] NOTE_HALF [0:31] = '{
        18'd0,
        18'd191110, 18'd170262, 18'd151686, 18'd143173,
        18'd127553, 18'd113636, 18'd101238,
        18'd95556,  18'd85131,  18'd75843,  18'd71586,
        18'd63776,  18'd56818,  18'd50619,
        18'd47778,  18'd42566,  18'd37922,  18'd35793,
        18'd31888,  18'd28409,  18'd25310,
        18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
        18'd0, 18'd0, 18'd0, 18'd0, 18'd0
    };

    function automatic logic [HALF_W-1:0] half_of(
        input logic [4:0]  note,
        input int unsigned shift
    );
        logic [HALF_W-1:0] h;
        h = NOTE_HALF[note] >> shift;
        if (NOTE_HALF[note] != '0 && h == '0) begin
            h = {{(HALF_W-1){1'b0}}, 1'b1};
        end
        return h;
    endfunction

endpackage

// File: rtl/tone_player_divider.sv
// Square-wave generator: counts clocks up to the half-period and
// toggles the output each time the count wraps.
module tone_player_divider
    import tone_player_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [HALF_W-1:0] i_half,
    output logic              o_wave
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_wave;
    logic [HALF_W-1:0] w_last;

    assign w_last = i_half - {{(HALF_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_en) begin
            if (r_cnt >= w_last) begin
                r_cnt  <= '0;
                r_wave <= ~r_wave;
            end else begin
                r_cnt <= r_cnt + {{(HALF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/tone_player.sv
// Plays one note command at a time on the buzzer pin, then holds the
// pin silent for a fixed gap before reporting completion.
module tone_player
    import tone_player_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TIME_1MS   = 100_000,
    parameter int unsigned GAP_MS     = 10,
    parameter int unsigned DUR_W      = 12,
    parameter int unsigned TONE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [4:0]       i_cmd_note,
    input  logic [DUR_W-1:0] i_cmd_dur,
    input  logic             i_stop,
    output logic             o_buzzer,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned TICK_W =
        (TIME_1MS > 1) ? $clog2(TIME_1MS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIME_1MS - 1);
    localparam logic [DUR_W-1:0]  GAP_END   = DUR_W'(GAP_MS);
    localparam logic [DUR_W-1:0]  MS_ONE    = DUR_W'(1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam bit                HAS_GAP   = (GAP_MS != 0);

    if (CLK_HZ != TABLE_CLK_HZ) begin : g_clk_chk
        $error("NOTE_HALF table is built for a 100 MHz clock");
    end

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              w_done_next;
    logic [4:0]        r_note;
    logic [DUR_W-1:0]  r_dur;
    logic [TICK_W-1:0] r_tick;
    logic [DUR_W-1:0]  r_ms;

    logic              w_accept;
    logic              w_wrap;
    logic [DUR_W-1:0]  w_ms_next;
    logic              w_play_end;
    logic              w_gap_end;
    logic              w_cnt_clr;
    logic [HALF_W-1:0] w_half;
    logic              w_tone_clr;
    logic              w_tone_en;
    logic              w_wave;

    assign w_accept = i_cmd_valid && r_ready && !i_stop
                      && (r_state == ST_IDLE);
    assign w_wrap     = (r_tick == TICK_LAST);
    assign w_ms_next  = r_ms + MS_ONE;
    assign w_play_end = (r_state == ST_PLAY) && w_wrap
                        && (w_ms_next == r_dur);
    assign w_gap_end  = (r_state == ST_GAP) && w_wrap
                        && (w_ms_next == GAP_END);

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        if (i_stop) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A zero-length command is swallowed without playing.
                    if (w_accept && i_cmd_dur != '0) begin
                        w_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_play_end) begin
                        w_next      = HAS_GAP ? ST_GAP : ST_IDLE;
                        w_done_next = !HAS_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_next      = ST_IDLE;
                        w_done_next = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Ready only after a full idle cycle, so completion and the
            // next accept are always separated by one cycle.
            r_ready <= !i_stop && (r_state == ST_IDLE)
                       && (w_next == ST_IDLE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_note <= '0;
            r_dur  <= '0;
        end else if (w_accept) begin
            r_note <= i_cmd_note;
            r_dur  <= i_cmd_dur;
        end
    end

    assign w_cnt_clr = (r_state == ST_IDLE) || (w_next != r_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (w_cnt_clr) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (w_wrap) begin
            r_tick <= '0;
            r_ms   <= w_ms_next;
        end else begin
            r_tick <= r_tick + TICK_ONE;
        end
    end

    assign w_half     = half_of(r_note, TONE_SHIFT);
    assign w_tone_clr = (r_state != ST_PLAY) || (w_next != ST_PLAY);
    assign w_tone_en  = !w_tone_clr && (w_half != '0);

    tone_player_divider u_tone_divider (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tone_en),
        .i_clr  (w_tone_clr),
        .i_half (w_half),
        .o_wave (w_wave)
    );

    assign o_buzzer    = w_wave;
    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a 100-cycle millisecond,
// a 2 ms gap and half-periods shifted down by 10.
module tb_tone_player;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_note = 5'd0;
    logic [11:0] cmd_dur = 12'd0;
    logic        stop = 1'b0;
    logic        buzzer;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    int n_hi, n_busy, n_done, t_done, t_rdy;
    int n_tog, t_tog1, t_tog2, n_rdy_busy;

    always #5 clk = ~clk;

    tone_player #(
        .CLK_HZ     (100_000_000),
        .TIME_1MS   (100),
        .GAP_MS     (2),
        .DUR_W      (12),
        .TONE_SHIFT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_note  (cmd_note),
        .i_cmd_dur   (cmd_dur),
        .i_stop      (stop),
        .o_buzzer    (buzzer),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    // Samples at each falling edge for n cycles; k = 0 is the call cycle.
    task automatic watch(input int n);
        logic prev;
        prev = 1'b0;
        n_hi = 0; n_busy = 0; n_done = 0; n_tog = 0; n_rdy_busy = 0;
        t_done = -1; t_rdy = -1; t_tog1 = -1; t_tog2 = -1;
        for (int k = 0; k < n; k++) begin
            if (buzzer) n_hi++;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
            if (cmd_ready && t_rdy < 0) t_rdy = k;
            if (cmd_ready && busy) n_rdy_busy++;
            if (buzzer != prev) begin
                n_tog++;
                if (n_tog == 1) t_tog1 = k;
                if (n_tog == 2) t_tog2 = k;
            end
            prev = buzzer;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [4:0] note, input logic [11:0] dur);
        cmd_valid = 1'b1;
        cmd_note  = note;
        cmd_dur   = dur;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_buzz", buzzer, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // A4: half-period 110, 3 ms play, 2 ms gap
        issue(5'd6, 12'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("a4_entry_busy", busy, 1);
        check("a4_entry_ready", cmd_ready, 0);
        watch(520);
        check("a4_tog1", t_tog1, 110);
        check("a4_tog2", t_tog2, 220);
        check("a4_ntog", n_tog, 2);
        check("a4_hi", n_hi, 110);
        check("a4_busy", n_busy, 500);
        check("a4_ndone", n_done, 1);
        check("a4_tdone", t_done, 500);
        check("a4_trdy", t_rdy, 501);
        check("a4_rdy_busy", n_rdy_busy, 0);

        // Rest code: silent but timed like a note
        issue(5'd0, 12'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        watch(420);
        check("rest_hi", n_hi, 0);
        check("rest_busy", n_busy, 400);
        check("rest_ndone", n_done, 1);
        check("rest_tdone", t_done, 400);
        check("rest_trdy", t_rdy, 401);

        // Zero duration consumed silently, then C4 for 1 ms
        issue(5'd6, 12'd0);
        @(negedge clk);
        check("dur0_busy", busy, 0);
        check("dur0_ready", cmd_ready, 1);
        check("dur0_done", done, 0);
        issue(5'd1, 12'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("c4_entry_busy", busy, 1);
        watch(320);
        check("c4_hi", n_hi, 0);
        check("c4_busy", n_busy, 300);
        check("c4_ndone", n_done, 1);
        check("c4_tdone", t_done, 300);

        // Stop mid-note with the command held valid
        issue(5'd6, 12'd3);
        @(negedge clk);
        repeat (150) @(negedge clk);
        check("stop_pre_buzz", buzzer, 1);
        stop = 1'b1;
        @(negedge clk);
        check("stop_busy", busy, 0);
        check("stop_buzz", buzzer, 0);
        check("stop_ready", cmd_ready, 0);
        check("stop_done", done, 0);
        stop = 1'b0;
        @(negedge clk);
        check("stop_rel_ready", cmd_ready, 1);
        check("stop_rel_busy", busy, 0);
        check("stop_rel_done", done, 0);
        @(negedge clk);
        check("stop_reaccept", busy, 1);

        // Back-to-back with valid still high
        watch(502);
        check("b2b_busy", n_busy, 500);
        check("b2b_tdone", t_done, 500);
        check("b2b_ndone", n_done, 1);
        check("b2b_trdy", t_rdy, 501);
        check("b2b_rdy_busy", n_rdy_busy, 0);
        check("b2b_accept", busy, 1);
        cmd_valid = 1'b0;

        // Asynchronous reset in the middle of the third note
        repeat (148) @(negedge clk);
        check("arst_pre_buzz", buzzer, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_buzz", buzzer, 0);
        check("arst_ready", cmd_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
